// File: rtl/test_result_collector.sv
// test_result_collector: folds per-stage check verdicts into per-instruction outcomes, counts them and queues failures; optional RESULT_COLLECTOR_STOP_ON_FAIL_EN halts on first fail.
module test_result_collector #(
  parameter int PC_WIDTH   = 16,
  parameter int STAGE_W    = 3,
  parameter int WB_STAGE   = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      chk_valid,
  input  logic                      chk_result,
  input  logic [PC_WIDTH-1:0]       chk_pc,
  input  logic [STAGE_W-1:0]        chk_stage,
  output logic [CNT_WIDTH-1:0]      pass_count,
  output logic [CNT_WIDTH-1:0]      fail_count,
  output logic [CNT_WIDTH-1:0]      skip_count,
  output logic                      fail_valid,
  input  logic                      fail_ready,
  output logic [PC_WIDTH-1:0]       fail_pc,
  output logic [(1<<STAGE_W)-1:0]   fail_stages,
  output logic                      overflow,
  output logic                      halt
);
  localparam int MW = 1 << STAGE_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  logic          seen, run, active, boundary, commit, cur_seen, is_fail;
  logic [MW-1:0] mask, cur_mask;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, pop, push_req, push;
  logic [PC_WIDTH-1:0] pc_mem [FIFO_DEPTH];
  logic [MW-1:0]       st_mem [FIFO_DEPTH];
  assign boundary = chk_stage == STAGE_W'(WB_STAGE);
  assign cur_seen = seen | chk_valid;
  assign cur_mask = mask | ((chk_valid && !chk_result) ? (MW'(1) << chk_stage) : '0);
  assign active   = run && !clear;
  assign commit   = active && boundary;
  assign is_fail  = |cur_mask;
  assign full     = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign fail_valid = wr_ptr != rd_ptr;
  assign pop      = fail_valid && fail_ready;
  assign push_req = commit && is_fail;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push     = push_req && (!full || pop);
  assign fail_pc     = pc_mem[rd_ptr[AW-1:0]];
  assign fail_stages = st_mem[rd_ptr[AW-1:0]];
`ifdef RESULT_COLLECTOR_STOP_ON_FAIL_EN
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (clear) state_nx = RUN;
    else if (push_req) state_nx = HALTED;
  end
  assign run  = state == RUN;
  assign halt = state == HALTED;
`else
  assign run  = 1'b1;
  assign halt = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      seen <= 1'b0;
      mask <= '0;
    end else if (active) begin
      seen <= boundary ? 1'b0 : cur_seen;
      mask <= boundary ? '0 : cur_mask;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pass_count <= '0;
      fail_count <= '0;
      skip_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      pass_count <= '0;
      fail_count <= '0;
      skip_count <= '0;
      overflow   <= 1'b0;
    end else if (commit) begin
      skip_count <= skip_count + CNT_WIDTH'(!cur_seen && ~&skip_count);
      pass_count <= pass_count + CNT_WIDTH'(cur_seen && !is_fail && ~&pass_count);
      fail_count <= fail_count + CNT_WIDTH'(is_fail && ~&fail_count);
      overflow   <= overflow | (push_req && !push);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i] <= '0;
        st_mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr[AW-1:0]] <= chk_pc;
        st_mem[wr_ptr[AW-1:0]] <= cur_mask;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule
